// File: rtl/tick_pkg.sv
// Shared constants, channel action encoding and gravity period table
// for the multi-channel tick generator.
package tick_pkg;

  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned PERIOD_1S    = 100000000;
  localparam int unsigned PERIOD_100MS = 10000000;
  localparam int unsigned PERIOD_1MS   = 100000;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_RUN,
    ACT_CLEAR,
    ACT_LOAD
  } act_e;

  // Gravity drop period per game level, fastest at the top level.
  function automatic logic [31:0] level_period(
    input logic [3:0] level
  );
    logic [31:0] p;
    unique case (level)
      4'd0:    p = PERIOD_1S;
      4'd1:    p = PERIOD_100MS * 9;
      4'd2:    p = PERIOD_100MS * 8;
      4'd3:    p = PERIOD_100MS * 7;
      4'd4:    p = PERIOD_100MS * 6;
      4'd5:    p = PERIOD_100MS * 5;
      4'd6:    p = PERIOD_100MS * 4;
      4'd7:    p = PERIOD_100MS * 3;
      4'd8:    p = PERIOD_100MS * 2;
      4'd9:    p = PERIOD_100MS;
      4'd10:   p = PERIOD_1MS * 80;
      4'd11:   p = PERIOD_1MS * 65;
      4'd12:   p = PERIOD_1MS * 50;
      4'd13:   p = PERIOD_1MS * 35;
      4'd14:   p = PERIOD_1MS * 25;
      default: p = PERIOD_1MS * 16;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, period register and tick flop.
// Optional square output under SQUARE_OUT_EN.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD =
    CNT_W'(PERIOD_1S)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic             tick,
`ifdef SQUARE_OUT_EN
  output logic             sq,
`endif
  output logic [CNT_W-1:0] period_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] period_nx;
  logic             tick_nx;
  logic             wrap;
  logic             clr;
  act_e             act;

  assign clr        = restart | sync;
  assign wrap       = (count == period_r - ONE);
  assign period_out = period_r;

  // Priority decode: load beats clear beats run.
  always_comb begin
    act = ACT_HOLD;
    unique case (1'b1)
      load:                    act = ACT_LOAD;
      (!load && clr):          act = ACT_CLEAR;
      (!load && !clr && enable):
                               act = ACT_RUN;
      default:                 act = ACT_HOLD;
    endcase
  end

  // Next counter, period and tick values.
  always_comb begin
    count_nx  = count;
    period_nx = period_r;
    tick_nx   = 1'b0;
    unique case (act)
      ACT_LOAD: begin
        period_nx = (period_in == '0) ? ONE
                                      : period_in;
        count_nx  = '0;
      end
      ACT_CLEAR: count_nx = '0;
      ACT_RUN: begin
        if (wrap) begin
          count_nx = '0;
          tick_nx  = 1'b1;
        end else begin
          count_nx = count + ONE;
        end
      end
      default: ;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      period_r <= DEFAULT_PERIOD;
      tick     <= 1'b0;
    end else begin
      count    <= count_nx;
      period_r <= period_nx;
      tick     <= tick_nx;
    end
  end

`ifdef SQUARE_OUT_EN
  logic sq_nx;

  // Square wave toggles with each tick, clears on load/clear.
  always_comb begin
    sq_nx = sq;
    unique case (act)
      ACT_LOAD:  sq_nx = 1'b0;
      ACT_CLEAR: sq_nx = 1'b0;
      ACT_RUN:   sq_nx = wrap ? ~sq : sq;
      default:   sq_nx = sq;
    endcase
  end

  // Square output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sq <= 1'b0;
    else     sq <= sq_nx;
  end
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator top.
// Build option: SQUARE_OUT_EN adds the sq outputs.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = PERIOD_1S
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       restart,
  input  logic                    sync_all,
  input  logic [NUM_CH-1:0]       period_load,
  input  logic [NUM_CH*CNT_W-1:0] period_in,
  output logic [NUM_CH-1:0]       tick,
`ifdef SQUARE_OUT_EN
  output logic [NUM_CH-1:0]       sq,
`endif
  output logic [NUM_CH*CNT_W-1:0] period_out
);

  localparam logic [CNT_W-1:0] DEF_P =
    CNT_W'(DEFAULT_PERIOD);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEF_P)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable[i]),
      .restart    (restart[i]),
      .sync       (sync_all),
      .load       (period_load[i]),
      .period_in  (period_in[i*CNT_W +: CNT_W]),
      .tick       (tick[i]),
`ifdef SQUARE_OUT_EN
      .sq         (sq[i]),
`endif
      .period_out (period_out[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed plus random bench for tick_gen_multi,
// checked against an elapsed-cycle reference model.
module tb_tick_gen_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DP  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  enable = '0;
  logic [NCH-1:0]  restart = '0;
  logic            sync_all = 1'b0;
  logic [NCH-1:0]  period_load = '0;
  logic [NCH*CW-1:0] period_in = '0;
  logic [NCH-1:0]  tick;
  logic [NCH*CW-1:0] period_out;
`ifdef SQUARE_OUT_EN
  logic [NCH-1:0]  sq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: enabled cycles since last clear, and period.
  int run [NCH];
  int per [NCH];
  logic [NCH-1:0] exp_tick;

  tick_gen_multi #(
    .NUM_CH         (NCH),
    .CNT_W          (CW),
    .DEFAULT_PERIOD (DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .restart     (restart),
    .sync_all    (sync_all),
    .period_load (period_load),
    .period_in   (period_in),
    .tick        (tick),
`ifdef SQUARE_OUT_EN
    .sq          (sq),
`endif
    .period_out  (period_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0;
      per[i] = DP;
    end
    exp_tick = '0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      exp_tick[i] = 1'b0;
      if (period_load[i]) begin
        v = int'(period_in[i*CW +: CW]);
        per[i] = (v == 0) ? 1 : v;
        run[i] = 0;
      end else if (restart[i] || sync_all) begin
        run[i] = 0;
      end else if (enable[i]) begin
        run[i]++;
        exp_tick[i] = (run[i] % per[i] == 0);
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [NCH*CW-1:0] ep;
    for (int i = 0; i < NCH; i++)
      ep[i*CW +: CW] = CW'(per[i]);
    chk({tag, "_tick"}, 32'(tick), 32'(exp_tick));
    chk({tag, "_per"}, 32'(period_out), 32'(ep));
`ifdef SQUARE_OUT_EN
    begin
      logic [NCH-1:0] es;
      for (int i = 0; i < NCH; i++)
        es[i] = ((run[i] / per[i]) % 2) == 1;
      chk({tag, "_sq"}, 32'(sq), 32'(es));
    end
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    model_reset();
    steps("reset", 2);
    chk("rst_tick_const", 32'(tick), 32'd0);
    chk("rst_per_const", 32'(period_out), 32'h0505);

    rst    = 1'b0;
    enable = 2'b11;
    steps("basic", 7);

    period_load = 2'b10;
    period_in   = {8'd3, 8'd0};
    step("load_ch1");
    period_load = '0;
    steps("after_load", 10);

    while (run[0] % per[0] != 2) step("align");
    enable[0] = 1'b0;
    steps("pause", 4);
    enable[0] = 1'b1;
    steps("resume", 12);

    period_load = 2'b01;
    period_in   = {8'd9, 8'd0};
    step("load0");
    period_load = '0;
    chk("clamp_const", 32'(period_out[CW-1:0]), 32'd1);
    steps("p1", 5);

    period_load = 2'b01;
    period_in   = {8'd0, 8'd5};
    step("ch0_p5");
    period_load = '0;
    steps("skew", 2);
    sync_all    = 1'b1;
    period_load = 2'b10;
    period_in   = {8'd5, 8'd0};
    step("sync_load");
    sync_all    = 1'b0;
    period_load = '0;
    steps("lockstep", 12);

    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    compare("async_rst");
    chk("async_tick_const", 32'(tick), 32'd0);
    step("rst_hold");
    rst = 1'b0;
    steps("post_rst", 12);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) begin
        enable[i]      = ($urandom_range(0, 7) != 0);
        restart[i]     = ($urandom_range(0, 29) == 0);
        period_load[i] = ($urandom_range(0, 39) == 0);
        period_in[i*CW +: CW] =
          CW'($urandom_range(0, 9));
      end
      sync_all = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
